dp_ram_arb: RTL and testbench
=============================

# dp_ram_arb

Round-robin arbiter and sequencer in front of the two-port synchronous RAM. It shares RAM ports A and B among `NUM_REQ` requesters and grants up to two non-conflicting requests per cycle. It never issues a same-address write collision, so the RAM never drives undefined read data. After every reset it clears the whole RAM to zero before accepting traffic.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 4: RAM address width (depth `2**ADDR_WIDTH`, even).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in `[NUM_REQ]`: request present.
- `req_wr` in `[NUM_REQ]`: 1 = write, 0 = read.
- `req_addr` in `[NUM_REQ][ADDR_WIDTH]`: target address.
- `req_wdata` in `[NUM_REQ][DATA_WIDTH]`: write data.
- `req_ready` out `[NUM_REQ]`: grant; the request is transferred when valid && ready.
- `rsp_valid` out `[NUM_REQ]`: response for the granted request.
- `rsp_rdata` out `[NUM_REQ][DATA_WIDTH]`: read data, or the written data for writes.
- `init_done` out 1: RAM clear finished.
- `ram_wrA`/`ram_addrA`/`ram_dataA_in` out; `ram_dataA_out` in: RAM port A.
- `ram_wrB`/`ram_addrB`/`ram_dataB_in` out; `ram_dataB_out` in: RAM port B.

## Operation
- FSM `INIT` → `RUN`. Reset enters `INIT`, clears `init_addr`, clears the pointer `ptr` to 0 and clears all `rsp_valid`.
- `INIT` (clear sequence):
  - Port A writes 0 to `init_addr`; port B writes 0 to `init_addr+1`.
  - `init_addr` steps by 2. After the write of the last pair (`2**ADDR_WIDTH-2`, `2**ADDR_WIDTH-1`), go to `RUN`.
  - `req_ready` is all 0 throughout `INIT`.
- `RUN`, port A pick: the first valid requester scanning from `ptr` upward, modulo `NUM_REQ`.
- `RUN`, port B pick: the first valid requester after A's winner, scanning to `ptr-1`, that does not conflict with A's winner.
- Conflict definition: equal address and at least one of the two is a write. A conflicting requester is skipped and stays pending.
- Ports with no winner drive `ram_wr*`=0 and hold address 0.
- RAM inputs are driven combinationally from the picks in the grant cycle, and `req_ready` is asserted to the winners in that cycle.
- Pointer update:
  - If any grant occurred, `ptr` ← (index of the last granted requester in scan order) + 1, modulo `NUM_REQ`.
  - Otherwise `ptr` is unchanged.
- Owner tracking: the requester index and a valid bit per port are registered. Next cycle, `rsp_valid[owner]`=1 and `rsp_rdata[owner]` = that port's RAM output. The RAM returns write data on writes.
- `rsp_rdata` for non-owners is held at its previous value.
- `init_done` = 1 exactly when the FSM is in `RUN`.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0, `ram_wr*`=0, `ram_addr*`=0, `ram_data*_in`=0.
- `INIT` lasts `2**(ADDR_WIDTH-1)` cycles (8 at default). `init_done` rises on the following cycle.
- Request-to-response latency is 1 cycle. Up to two grants per cycle; sustained throughput is 2 accesses per cycle when there are no conflicts.
- A write granted in cycle N is visible to any read granted in cycle N+1 or later.
- Requesters must hold their request stable until granted. The arbiter keeps no request storage.
- Reset asserted mid-operation: the in-flight response is dropped (`rsp_valid` stays 0) and `INIT` restarts from address 0.

## Configuration
- `DP_RAM_ARB_STATS_EN` defined:
  - Adds outputs `grant_cnt` [32] (total grants) and `conflict_cnt` [32] (cycles in which a valid requester was skipped for conflict).
  - Both counters saturate at all-ones, are cleared by `rst`, and do not count during `INIT`.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package `dp_ram_arb_pkg`: state enum (`INIT`, `RUN`), `IDX_W` = `$clog2(NUM_REQ)` helper function, `STAT_W` = 32.
- Sub-module `dp_ram_arb_rr_pick`: combinational round-robin pick of A and B winners with conflict masking. Inputs: `valid`, `wr`, `addr`, `ptr`. Outputs: indices and found flags.
- The top level holds the FSM, pointer, owner registers and stats counters. The RAM is instantiated by the parent.

## Test plan
All scenarios use `NUM_REQ`=4, `DATA_WIDTH`=8, `ADDR_WIDTH`=4.
- Reset release → 8 `INIT` cycles write 0 to addresses 0..15 in pairs; `init_done`=1 on cycle 9; `req_ready`=0 until then; reading address 9 afterwards returns 0x00.
- req0 writes addr 3 = 0xA5; next cycle req1 reads addr 3 → `rsp_valid[1]` one cycle later with 0xA5.
- With `ptr`=0, req0 and req2 both write addr 5 (0x11, 0x22) → req0 granted alone; req2 granted next cycle; a later read of addr 5 returns 0x22; `conflict_cnt`=1.
- req1 writes addr 7 = 0x3C while req3 reads addr 7, same cycle, `ptr`=0 → req1 only; req3 granted next cycle and receives 0x3C.
- All four requesters issue continuous reads of distinct addresses → grant pairs (0,1), (2,3), (0,1); `ptr` sequence 0, 2, 0; `grant_cnt`=6.
- `rst` pulsed the cycle after a read grant → no `rsp_valid`; `init_done` drops; full 8-cycle `INIT` repeats.

Source files
------------

// File: rtl/dp_ram_arb_pkg.sv
// dp_ram_arb_pkg: shared types and constants for the dual-port RAM arbiter.
//   state_e : arbiter FSM states (INIT clears the RAM, RUN arbitrates).
//   STAT_W  : width of the optional statistics counters.
//   idx_w() : width of a requester index for a given requester count.
// Optional feature macro used by this block: DP_RAM_ARB_STATS_EN.
package dp_ram_arb_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned STAT_W = 32;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dp_ram_arb_if.sv
// dp_ram_arb_if: requester-side bus of the dual-port RAM arbiter.
//   req_valid/req_wr/req_addr/req_wdata : per-requester access request
//   req_ready                           : per-requester grant (transfer on valid && ready)
//   rsp_valid/rsp_rdata                 : per-requester response, one cycle after grant
// Modports: master (requesters), slave (arbiter).
interface dp_ram_arb_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
);

   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_wr;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/dp_ram_arb_rr_pick.sv
// dp_ram_arb_rr_pick: combinational round-robin pick of up to two requesters.
//   valid, wr, addr : per-requester request fields
//   ptr             : requester with highest priority this cycle
//   a_idx, a_found  : first valid requester scanning upward from ptr
//   b_idx, b_found  : next valid requester after A (up to ptr-1) not conflicting with A
//   conflict        : a valid requester was skipped because it conflicts with A
module dp_ram_arb_rr_pick
   import dp_ram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 4,
   localparam int unsigned IDX_W     = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]                 valid,
   input  logic [NUM_REQ-1:0]                 wr,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr,
   input  logic [IDX_W-1:0]                   ptr,
   output logic [IDX_W-1:0]                   a_idx,
   output logic                               a_found,
   output logic [IDX_W-1:0]                   b_idx,
   output logic                               b_found,
   output logic                               conflict
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   // Single scan from ptr: the first valid hit becomes A, later hits are B candidates.
   always_comb begin
      a_idx    = '0;
      a_found  = 1'b0;
      b_idx    = '0;
      b_found  = 1'b0;
      conflict = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         idx = sum[IDX_W-1:0];
         if (!a_found && valid[idx]) begin
            a_found = 1'b1;
            a_idx   = idx;
         end else if (a_found && !b_found && valid[idx]) begin
            // Same address with any write would collide inside the RAM: leave it pending.
            if (addr[idx] == addr[a_idx] && (wr[idx] || wr[a_idx])) begin
               conflict = 1'b1;
            end else begin
               b_found = 1'b1;
               b_idx   = idx;
            end
         end
      end
   end

endmodule

// File: rtl/dp_ram_arb.sv
// dp_ram_arb: round-robin arbiter/sequencer sharing the two ports of a synchronous RAM.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : requester bus (request, grant, response)
//   init_done           : high once the post-reset RAM clear has finished
//   ram_wrA/ram_addrA/ram_dataA_in, ram_dataA_out : RAM port A
//   ram_wrB/ram_addrB/ram_dataB_in, ram_dataB_out : RAM port B
//   grant_cnt, conflict_cnt : saturating statistics, present only with DP_RAM_ARB_STATS_EN
// After reset the RAM is cleared two words per cycle, then up to two non-conflicting
// requests are granted per cycle; responses come one cycle after the grant.
module dp_ram_arb
   import dp_ram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   dp_ram_arb_if.slave           bus,
   output logic                  init_done,
   output logic                  ram_wrA,
   output logic [ADDR_WIDTH-1:0] ram_addrA,
   output logic [DATA_WIDTH-1:0] ram_dataA_in,
   input  logic [DATA_WIDTH-1:0] ram_dataA_out,
   output logic                  ram_wrB,
   output logic [ADDR_WIDTH-1:0] ram_addrB,
   output logic [DATA_WIDTH-1:0] ram_dataB_in,
   input  logic [DATA_WIDTH-1:0] ram_dataB_out
`ifdef DP_RAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]     grant_cnt,
   output logic [STAT_W-1:0]     conflict_cnt
`endif
);

   localparam int unsigned IDX_W = idx_w(NUM_REQ);
   localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

   state_e                             state_q, state_d;
   logic [ADDR_WIDTH-1:0]              init_addr_q, init_addr_d;
   logic [IDX_W-1:0]                   ptr_q, ptr_d;
   logic [IDX_W-1:0]                   own_a_q, own_b_q;
   logic                               own_a_vld_q, own_b_vld_q;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rdata_q;

   logic [IDX_W-1:0] a_idx, b_idx;
   logic             a_found, b_found, conflict;
   logic             grant_a, grant_b;

   function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
      return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   dp_ram_arb_rr_pick #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pick (
      .valid    (bus.req_valid),
      .wr       (bus.req_wr),
      .addr     (bus.req_addr),
      .ptr      (ptr_q),
      .a_idx    (a_idx),
      .a_found  (a_found),
      .b_idx    (b_idx),
      .b_found  (b_found),
      .conflict (conflict)
   );

   // Everything is forced idle while rst is high so no RAM write or grant leaks out.
   always_comb begin
      state_d       = state_q;
      init_addr_d   = init_addr_q;
      ptr_d         = ptr_q;
      grant_a       = 1'b0;
      grant_b       = 1'b0;
      ram_wrA       = 1'b0;
      ram_addrA     = '0;
      ram_dataA_in  = '0;
      ram_wrB       = 1'b0;
      ram_addrB     = '0;
      ram_dataB_in  = '0;
      bus.req_ready = '0;
      if (!rst) begin
         case (state_q)
            INIT: begin
               ram_wrA     = 1'b1;
               ram_addrA   = init_addr_q;
               ram_wrB     = 1'b1;
               ram_addrB   = init_addr_q | ADDR_WIDTH'(1);
               init_addr_d = init_addr_q + ADDR_WIDTH'(2);
               if (init_addr_q == LAST_PAIR) begin
                  state_d     = RUN;
                  init_addr_d = '0;
               end
            end
            RUN: begin
               grant_a = a_found;
               grant_b = b_found;
               if (a_found) begin
                  ram_wrA              = bus.req_wr[a_idx];
                  ram_addrA            = bus.req_addr[a_idx];
                  ram_dataA_in         = bus.req_wdata[a_idx];
                  bus.req_ready[a_idx] = 1'b1;
                  ptr_d                = inc_idx(a_idx);
               end
               // B always lies later in scan order than A, so it sets the pointer.
               if (b_found) begin
                  ram_wrB              = bus.req_wr[b_idx];
                  ram_addrB            = bus.req_addr[b_idx];
                  ram_dataB_in         = bus.req_wdata[b_idx];
                  bus.req_ready[b_idx] = 1'b1;
                  ptr_d                = inc_idx(b_idx);
               end
            end
            default: ;
         endcase
      end
   end

   // Owners see the RAM output directly; everyone else keeps their last response data.
   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_rdata = rdata_q;
      if (rst) begin
         bus.rsp_rdata = '0;
      end else begin
         if (own_a_vld_q) begin
            bus.rsp_valid[own_a_q] = 1'b1;
            bus.rsp_rdata[own_a_q] = ram_dataA_out;
         end
         if (own_b_vld_q) begin
            bus.rsp_valid[own_b_q] = 1'b1;
            bus.rsp_rdata[own_b_q] = ram_dataB_out;
         end
      end
   end

   assign init_done = (state_q == RUN) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         ptr_q       <= '0;
         own_a_q     <= '0;
         own_b_q     <= '0;
         own_a_vld_q <= 1'b0;
         own_b_vld_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         ptr_q       <= ptr_d;
         own_a_q     <= a_idx;
         own_b_q     <= b_idx;
         own_a_vld_q <= grant_a;
         own_b_vld_q <= grant_b;
         rdata_q     <= bus.rsp_rdata;
      end
   end

`ifdef DP_RAM_ARB_STATS_EN
   logic [STAT_W-1:0] grant_cnt_q, conflict_cnt_q;
   logic [STAT_W:0]   grant_sum, conflict_sum;
   logic              conflict_hit;

   assign conflict_hit = (state_q == RUN) && !rst && conflict;

   // One spare bit catches the carry so the counters stick at all-ones.
   always_comb begin
      grant_sum    = {1'b0, grant_cnt_q} + (STAT_W+1)'(grant_a) + (STAT_W+1)'(grant_b);
      conflict_sum = {1'b0, conflict_cnt_q} + (STAT_W+1)'(conflict_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         grant_cnt_q    <= grant_sum[STAT_W] ? '1 : grant_sum[STAT_W-1:0];
         conflict_cnt_q <= conflict_sum[STAT_W] ? '1 : conflict_sum[STAT_W-1:0];
      end
   end

   assign grant_cnt    = grant_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`else
   logic unused_conflict;
   assign unused_conflict = conflict;
`endif

endmodule

// File: tb/tb_dp_ram_arb.sv
// tb_dp_ram_arb: directed scoreboard bench for dp_ram_arb with a behavioural RAM.
// Stimulus pushes expected responses per requester; a negedge monitor pops and
// compares every response and every posted control check.
module tb_dp_ram_arb;
   import dp_ram_arb_pkg::*;

   logic clk;
   logic rst;
   logic scramble;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dp_ram_arb_if #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   logic       init_done;
   logic       ram_wrA, ram_wrB;
   logic [3:0] ram_addrA, ram_addrB;
   logic [7:0] ram_dataA_in, ram_dataB_in, ram_dataA_out, ram_dataB_out;
`ifdef DP_RAM_ARB_STATS_EN
   logic [31:0] grant_cnt, conflict_cnt;
`endif

   dp_ram_arb #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .init_done     (init_done),
      .ram_wrA       (ram_wrA),
      .ram_addrA     (ram_addrA),
      .ram_dataA_in  (ram_dataA_in),
      .ram_dataA_out (ram_dataA_out),
      .ram_wrB       (ram_wrB),
      .ram_addrB     (ram_addrB),
      .ram_dataB_in  (ram_dataB_in),
      .ram_dataB_out (ram_dataB_out)
`ifdef DP_RAM_ARB_STATS_EN
      ,
      .grant_cnt     (grant_cnt),
      .conflict_cnt  (conflict_cnt)
`endif
   );

   // Synchronous two-port RAM; a write returns the written data. Scramble fills with 0xEE.
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
         ram_dataA_out <= 8'hEE;
         ram_dataB_out <= 8'hEE;
      end else begin
         if (ram_wrA) begin
            mem[ram_addrA] <= ram_dataA_in;
            ram_dataA_out  <= ram_dataA_in;
         end else begin
            ram_dataA_out  <= mem[ram_addrA];
         end
         if (ram_wrB) begin
            mem[ram_addrB] <= ram_dataB_in;
            ram_dataB_out  <= ram_dataB_in;
         end else begin
            ram_dataB_out  <= mem[ram_addrB];
         end
      end
   end

   typedef struct {
      string       name;
      logic [63:0] act;
      logic [63:0] exp;
   } chk_t;

   chk_t       post_q [$];
   logic [7:0] exp_q [4][$];
   logic [3:0] gnt_log [$];
   int         checks = 0;
   int         errors = 0;

   // Monitor: the only place comparisons are counted.
   always @(negedge clk) begin
      chk_t       c;
      logic [7:0] e;
      while (post_q.size() > 0) begin
         c = post_q.pop_front();
         checks++;
         if (c.act !== c.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.rsp_valid[i] === 1'b1) begin
            checks++;
            if (exp_q[i].size() == 0) begin
               errors++;
               $display("FAIL rsp%0d_unexpected: got 0x%0h expected no response", i,
                        bus.rsp_rdata[i]);
            end else begin
               e = exp_q[i].pop_front();
               if (bus.rsp_rdata[i] !== e) begin
                  errors++;
                  $display("FAIL rsp%0d_data: got 0x%0h expected 0x%0h", i, bus.rsp_rdata[i], e);
               end
            end
         end
      end
   end

   task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_t c;
      c.name = name;
      c.act  = act;
      c.exp  = exp;
      post_q.push_back(c);
   endtask

   task automatic set_req(input int i, input logic wr, input logic [3:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp);
      bus.req_valid[i] = 1'b1;
      bus.req_wr[i]    = wr;
      bus.req_addr[i]  = addr;
      bus.req_wdata[i] = wdata;
      exp_q[i].push_back(exp);
   endtask

   // Hold requests until granted; each requester drops valid after its grant.
   task automatic run_reqs(input int budget);
      int         n;
      logic [3:0] g;
      gnt_log.delete();
      n = 0;
      while (bus.req_valid != 4'b0000 && n < budget) begin
         @(negedge clk);
         g = bus.req_valid & bus.req_ready;
         gnt_log.push_back(g);
         @(posedge clk);
         #1;
         bus.req_valid = bus.req_valid & ~g;
         n++;
      end
      post("all_granted", 64'(bus.req_valid), 64'(0));
      bus.req_valid = '0;
   endtask

   task automatic check_gnts(input string name, input int n, input logic [15:0] pat);
      logic [15:0] act;
      act = '0;
      for (int k = 0; k < gnt_log.size() && k < 4; k++) act[4*k +: 4] = gnt_log[k];
      post(name, 64'({8'(gnt_log.size()), act}), 64'({8'(n), pat}));
   endtask

   // Eight clear cycles: pairs (2c, 2c+1) written with zero, no grants, init_done low.
   task automatic check_init();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         post($sformatf("init_cyc%0d", c + 1),
              64'({ram_wrA, ram_wrB, ram_addrA, ram_addrB, ram_dataA_in, ram_dataB_in,
                   init_done, bus.req_ready}),
              64'({1'b1, 1'b1, 4'(2 * c), 4'(2 * c + 1), 8'h00, 8'h00, 1'b0, 4'b0000}));
         @(posedge clk);
      end
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      scramble      = 1'b1;
      bus.req_valid = '0;
      bus.req_wr    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      post("rst_ctrl", 64'({bus.req_ready, bus.rsp_valid, init_done, ram_wrA, ram_wrB}), 64'(0));
      post("rst_ram", 64'({ram_addrA, ram_dataA_in, ram_addrB, ram_dataB_in}), 64'(0));
      post("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
      @(posedge clk);
      #1;
      rst      = 1'b0;
      scramble = 1'b0;

      // Clear sequence with a read of address 9 pending throughout.
      set_req(0, 1'b0, 4'd9, 8'h00, 8'h00);
      check_init();
      run_reqs(4);
      check_gnts("t1_grant_cycle9", 1, 16'h0001);
      idle(2);

      // Write then read-after-write on the next cycle.
      set_req(0, 1'b1, 4'd3, 8'hA5, 8'hA5);
      run_reqs(4);
      check_gnts("t2_wr", 1, 16'h0001);
      set_req(1, 1'b0, 4'd3, 8'h00, 8'hA5);
      run_reqs(4);
      check_gnts("t2_rd", 1, 16'h0002);
      idle(2);

      // req3 alone moves the pointer back to 0.
      set_req(3, 1'b0, 4'd0, 8'h00, 8'h00);
      run_reqs(4);
      check_gnts("ptr_align", 1, 16'h0008);
      idle(2);

      // Write/write conflict: req0 first, req2 next cycle.
      set_req(0, 1'b1, 4'd5, 8'h11, 8'h11);
      set_req(2, 1'b1, 4'd5, 8'h22, 8'h22);
      run_reqs(4);
      check_gnts("t3_ww_conflict", 2, 16'h0041);
      idle(2);
      set_req(3, 1'b0, 4'd5, 8'h00, 8'h22);
      run_reqs(4);
      check_gnts("t3_rd", 1, 16'h0008);
`ifdef DP_RAM_ARB_STATS_EN
      post("t3_conflict_cnt", 64'(conflict_cnt), 64'(1));
`endif
      idle(2);

      // Write/read conflict: req1 write first, req3 read gets the new data.
      set_req(1, 1'b1, 4'd7, 8'h3C, 8'h3C);
      set_req(3, 1'b0, 4'd7, 8'h00, 8'h3C);
      run_reqs(4);
      check_gnts("t4_wr_rd", 2, 16'h0082);
      idle(2);
`ifdef DP_RAM_ARB_STATS_EN
      post("t4_conflict_cnt", 64'(conflict_cnt), 64'(2));
`endif

      // Four continuous reads of distinct addresses for three cycles.
      set_req(0, 1'b0, 4'd3, 8'h00, 8'hA5);
      set_req(1, 1'b0, 4'd5, 8'h00, 8'h22);
      set_req(2, 1'b0, 4'd7, 8'h00, 8'h3C);
      set_req(3, 1'b0, 4'd9, 8'h00, 8'h00);
      exp_q[0].push_back(8'hA5);
      exp_q[1].push_back(8'h22);
      gnt_log.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         gnt_log.push_back(bus.req_valid & bus.req_ready);
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      check_gnts("t5_pairs", 3, 16'h03C3);
      idle(2);
`ifdef DP_RAM_ARB_STATS_EN
      post("t5_grant_cnt", 64'(grant_cnt), 64'(15));
`endif

      // Reset the cycle after a read grant: response dropped, clear sequence repeats.
      bus.req_valid[2] = 1'b1;
      bus.req_wr[2]    = 1'b0;
      bus.req_addr[2]  = 4'd3;
      run_reqs(4);
      check_gnts("t6_rd", 1, 16'h0004);
      rst = 1'b1;
      @(negedge clk);
      post("t6_rst_drop", 64'({bus.rsp_valid, init_done}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_req(0, 1'b0, 4'd3, 8'h00, 8'h00);
      check_init();
      run_reqs(4);
      check_gnts("t6_reinit_grant", 1, 16'h0001);
      idle(2);
`ifdef DP_RAM_ARB_STATS_EN
      post("t6_stats", 64'({grant_cnt, conflict_cnt}), 64'({32'd1, 32'd0}));
`endif

      post("queues_empty",
           64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'(0));
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
